row_fifo: RTL

Parametrised first-word-fall-through FIFO of WIDTH-bit words, generalising the single write-enabled register into a DEPTH-entry store with independent push and pop. It buffers cell rows between the row generator and the next-generation compute stage of the Conway pipeline. It provides occupancy flags, a count, a synchronous flush and, optionally, sticky error flags.

---
 rtl/row_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/row_fifo.sv
// First-word-fall-through FIFO buffering cell rows between the row generator and the compute stage.
// Define ROW_FIFO_ERR_EN to add sticky overflow (ovf) and underflow (unf) flags.
module row_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         d,
   input  logic                     we,
   input  logic                     re,
   output logic [WIDTH-1:0]         q,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
`ifdef ROW_FIFO_ERR_EN
   ,
   output logic                     ovf,
   output logic                     unf
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic             push;
   logic             pop;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign push  = we & (~full | re);
   assign pop   = re & ~empty;

   assign empty = (count == '0);
   assign full  = (count == FULL_COUNT);
   assign q     = empty ? '0 : mem[rp];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (clear) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Storage has no reset; stale words are never visible because q is masked by empty.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wp] <= d;
      end
   end

`ifdef ROW_FIFO_ERR_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else if (clear) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (we && !push) begin
            ovf <= 1'b1;
         end
         if (re && !pop) begin
            unf <= 1'b1;
         end
      end
   end
`endif

endmodule
